// File: rtl/vip_pkg.sv
// Shared constants and types for the video preprocessing chain.
// Frame geometry defaults, pixel width and window column type.
package vip_pkg;
    localparam int IMG_H_DISP_DFLT = 640;
    localparam int IMG_V_DISP_DFLT = 480;
    localparam int CNT_W_DFLT      = 11;
    localparam int PIX_W           = 8;
    localparam int WIN_ROWS        = 3;

    // One incoming window column, top (line n-2) to bottom (line n).
    typedef struct packed {
        logic [PIX_W-1:0] r1;
        logic [PIX_W-1:0] r2;
        logic [PIX_W-1:0] y;
    } win_col_t;
endpackage

// File: rtl/window_row_shift_8bit.sv
// One row of the 3x3 window: three pixel registers shifting left on enable.
// px1 is the oldest column, px3 the newest.
module window_row_shift_8bit
    import vip_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] px1,
    output logic [PIX_W-1:0] px2,
    output logic [PIX_W-1:0] px3
);
    always_ff @(posedge clock) begin
        if (reset) begin
            px1 <= '0;
            px2 <= '0;
            px3 <= '0;
        end else if (en) begin
            px1 <= px2;
            px2 <= px3;
            px3 <= din;
        end
    end
endmodule

// File: rtl/matrix_3x3_gen_8bit.sv
// Builds a registered 3x3 pixel window from the current line and two line taps,
// tracks row/column position for border flagging and delays the syncs by 1 cycle.
module matrix_3x3_gen_8bit
    import vip_pkg::*;
#(
    parameter int IMG_H_DISP = IMG_H_DISP_DFLT,
    parameter int IMG_V_DISP = IMG_V_DISP_DFLT,
    parameter int CNT_W      = CNT_W_DFLT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [PIX_W-1:0] per_img_y,
    input  logic [PIX_W-1:0] row1_data,
    input  logic [PIX_W-1:0] row2_data,
    output logic             matrix_frame_vsync,
    output logic             matrix_frame_href,
    output logic             matrix_frame_clken,
    output logic [PIX_W-1:0] matrix_p11,
    output logic [PIX_W-1:0] matrix_p12,
    output logic [PIX_W-1:0] matrix_p13,
    output logic [PIX_W-1:0] matrix_p21,
    output logic [PIX_W-1:0] matrix_p22,
    output logic [PIX_W-1:0] matrix_p23,
    output logic [PIX_W-1:0] matrix_p31,
    output logic [PIX_W-1:0] matrix_p32,
    output logic [PIX_W-1:0] matrix_p33,
    output logic             matrix_border,
    output logic             line_len_err
);
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(IMG_H_DISP);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(IMG_V_DISP);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    logic                                accept;
    logic                                vsync_rise;
    logic                                href_fall;
    logic [CNT_W-1:0]                    col_cnt;
    logic [CNT_W-1:0]                    row_cnt;
    win_col_t                            new_col;
    logic [WIN_ROWS-1:0][PIX_W-1:0]      row_din;
    logic [WIN_ROWS-1:0][PIX_W-1:0]      row_px1;
    logic [WIN_ROWS-1:0][PIX_W-1:0]      row_px2;
    logic [WIN_ROWS-1:0][PIX_W-1:0]      row_px3;

    assign accept     = per_frame_clken & per_frame_href;
    // The delayed syncs double as the previous-cycle samples for edge detection.
    assign vsync_rise = per_frame_vsync & ~matrix_frame_vsync;
    assign href_fall  = ~per_frame_href & matrix_frame_href;

    assign new_col = '{r1: row1_data, r2: row2_data, y: per_img_y};
    assign row_din = {new_col.y, new_col.r2, new_col.r1};

    for (genvar i = 0; i < WIN_ROWS; i++) begin : g_row
        window_row_shift_8bit u_row (
            .clock (clock),
            .reset (reset),
            .en    (accept),
            .din   (row_din[i]),
            .px1   (row_px1[i]),
            .px2   (row_px2[i]),
            .px3   (row_px3[i])
        );
    end

    assign matrix_p11 = row_px1[0];
    assign matrix_p12 = row_px2[0];
    assign matrix_p13 = row_px3[0];
    assign matrix_p21 = row_px1[1];
    assign matrix_p22 = row_px2[1];
    assign matrix_p23 = row_px3[1];
    assign matrix_p31 = row_px1[2];
    assign matrix_p32 = row_px2[2];
    assign matrix_p33 = row_px3[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            matrix_frame_vsync <= 1'b0;
            matrix_frame_href  <= 1'b0;
            matrix_frame_clken <= 1'b0;
        end else begin
            matrix_frame_vsync <= per_frame_vsync;
            matrix_frame_href  <= per_frame_href;
            matrix_frame_clken <= per_frame_clken;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !per_frame_href)
            col_cnt <= '0;
        else if (accept && col_cnt != H_MAX)
            col_cnt <= col_cnt + 1'b1;
    end

    // Clear on vsync rise takes priority over a coincident href fall.
    always_ff @(posedge clock) begin
        if (reset || vsync_rise)
            row_cnt <= '0;
        else if (href_fall && row_cnt != V_MAX)
            row_cnt <= row_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || vsync_rise)
            line_len_err <= 1'b0;
        else if (accept && col_cnt == H_MAX)
            line_len_err <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            matrix_border <= 1'b0;
        else
            matrix_border <= accept && (row_cnt < TWO || col_cnt < TWO);
    end
endmodule
